// File: rtl/mult_share_arbiter.sv
// Round-robin front end that time-shares one external combinational multiplier
// between NREQ requesters, with valid/ready handshakes on both the request and response sides.
module mult_share_arbiter #(
  parameter int NREQ    = 4,
  parameter int WIDTH   = 8,
  parameter int MUL_LAT = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req_valid,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ*WIDTH-1:0]   req_a,
  input  logic [NREQ*WIDTH-1:0]   req_b,
  output logic [NREQ-1:0]         rsp_valid,
  input  logic [NREQ-1:0]         rsp_ready,
  output logic [2*WIDTH-1:0]      rsp_p,
  output logic [WIDTH-1:0]        mul_a,
  output logic [WIDTH-1:0]        mul_b,
  input  logic [2*WIDTH-1:0]      mul_p,
  output logic                    busy
);

  localparam int PW = $clog2(NREQ);
  localparam int CW = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t             r_state;
  state_t             w_state_next;
  logic [PW-1:0]      r_ptr;
  logic [PW-1:0]      r_gnt;
  logic [CW-1:0]      r_cnt;
  logic [WIDTH-1:0]   r_op_a;
  logic [WIDTH-1:0]   r_op_b;
  logic [2*WIDTH-1:0] r_rsp_p;

  logic [PW-1:0]      w_g;
  logic [PW:0]        w_idx;
  logic               w_found;
  logic               w_hs;
  logic [WIDTH-1:0]   w_sel_a;
  logic [WIDTH-1:0]   w_sel_b;

  // Scan from the highest offset down so the requester closest to r_ptr wins.
  always_comb begin
    w_found = 1'b0;
    w_g     = '0;
    w_idx   = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      w_idx = {1'b0, r_ptr} + (PW+1)'(k);
      if (w_idx >= (PW+1)'(NREQ)) begin
        w_idx = w_idx - (PW+1)'(NREQ);
      end
      if (req_valid[w_idx[PW-1:0]]) begin
        w_found = 1'b1;
        w_g     = w_idx[PW-1:0];
      end
    end
  end

  assign w_hs    = (r_state == S_IDLE) && w_found;
  assign w_sel_a = req_a[w_g*WIDTH +: WIDTH];
  assign w_sel_b = req_b[w_g*WIDTH +: WIDTH];

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_onehot
      assign req_ready[gi] = w_hs && (w_g == PW'(gi));
      assign rsp_valid[gi] = (r_state == S_RESP) && (r_gnt == PW'(gi));
    end
  endgenerate

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (w_found) w_state_next = S_WAIT;
      S_WAIT:  if (r_cnt == '0) w_state_next = S_RESP;
      S_RESP:  if (rsp_ready[r_gnt]) w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_ptr   <= '0;
      r_gnt   <= '0;
      r_cnt   <= '0;
      r_op_a  <= '0;
      r_op_b  <= '0;
      r_rsp_p <= '0;
    end else begin
      r_state <= w_state_next;
      if (w_hs) begin
        r_op_a <= w_sel_a;
        r_op_b <= w_sel_b;
        r_gnt  <= w_g;
        r_ptr  <= (w_g == PW'(NREQ - 1)) ? '0 : w_g + 1'b1;
        r_cnt  <= CW'(MUL_LAT - 1);
      end
      // The product is sampled on the last settle cycle, after the operands have been stable for MUL_LAT cycles.
      if (r_state == S_WAIT) begin
        if (r_cnt == '0) begin
          r_rsp_p <= mul_p;
        end else begin
          r_cnt <= r_cnt - 1'b1;
        end
      end
    end
  end

  assign mul_a = r_op_a;
  assign mul_b = r_op_b;
  assign rsp_p = r_rsp_p;
  assign busy  = (r_state != S_IDLE);

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Self-checking bench for mult_share_arbiter: directed vector table, corner-case
// sequences, then randomized traffic against a round-robin reference model.
module tb_mult_share_arbiter;
  localparam int NREQ    = 4;
  localparam int WIDTH   = 8;
  localparam int MUL_LAT = 1;

  logic                  clk = 1'b0;
  logic                  rst = 1'b1;
  logic [NREQ-1:0]       req_valid = '0;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_a = '0;
  logic [NREQ*WIDTH-1:0] req_b = '0;
  logic [NREQ-1:0]       rsp_valid;
  logic [NREQ-1:0]       rsp_ready = '0;
  logic [2*WIDTH-1:0]    rsp_p;
  logic [WIDTH-1:0]      mul_a;
  logic [WIDTH-1:0]      mul_b;
  logic [2*WIDTH-1:0]    mul_p;
  logic                  busy;

  mult_share_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH), .MUL_LAT(MUL_LAT)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_p(rsp_p),
    .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p), .busy(busy)
  );

  // The shared multiplier the arbiter fronts.
  assign mul_p = {8'b0, mul_a} * {8'b0, mul_b};

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    int idx;
    int a;
    int b;
    int p;
  } vec_t;
  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic set_req(input int idx, input int a, input int b);
    logic [31:0] va;
    logic [31:0] vb;
    va = a;
    vb = b;
    req_valid[idx] = 1'b1;
    req_a[idx*WIDTH +: WIDTH] = va[WIDTH-1:0];
    req_b[idx*WIDTH +: WIDTH] = vb[WIDTH-1:0];
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0;
    rsp_ready = '0;
    @(negedge clk);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_rsp_p", rsp_p, 0);
    chk("rst_mul_a", mul_a, 0);
    chk("rst_mul_b", mul_b, 0);
    chk("rst_busy", busy, 0);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic wait_grant(input string name, input int exp_idx);
    int t;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (req_ready == 0 && t < 30);
    chk(name, req_ready, 32'd1 << exp_idx);
  endtask

  task automatic wait_rsp(input string name, input int exp_idx, input int exp_p, output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (rsp_valid == 0 && lat < 30);
    chk({name, "_valid"}, rsp_valid, 32'd1 << exp_idx);
    chk({name, "_p"}, rsp_p, exp_p);
  endtask

  task automatic run_single(input int idx, input int a, input int b, input int p);
    int lat;
    @(posedge clk); #1;
    set_req(idx, a, b);
    rsp_ready = '1;
    @(negedge clk);
    chk("vec_grant", req_ready, 32'd1 << idx);
    chk("vec_busy_idle", busy, 0);
    @(posedge clk); #1;
    req_valid[idx] = 1'b0;
    @(negedge clk);
    chk("vec_mul_a", mul_a, a);
    chk("vec_mul_b", mul_b, b);
    wait_rsp("vec_rsp", idx, p, lat);
    chk("vec_latency", lat + 1, MUL_LAT + 1);
    @(negedge clk);
    chk("vec_busy_after", busy, 0);
    $display("vec req=%0d a=%0d b=%0d p=%0d lat=%0d", idx, a, b, rsp_p, lat + 1);
  endtask

  initial begin
    int lat;
    int pend[NREQ];
    int opa[NREQ];
    int opb[NREQ];
    int ptr, mstate, cnt, eg, ep, jg, g, ntx;
    int gseq[$];

    vecs[0] = '{1, 15, 13, 195};
    vecs[1] = '{0, 255, 255, 65025};
    vecs[2] = '{0, 128, 2, 256};
    vecs[3] = '{0, 0, 0, 0};
    vecs[4] = '{3, 200, 100, 20000};
    vecs[5] = '{2, 1, 255, 255};
    vecs[6] = '{1, 255, 1, 255};

    do_reset();
    for (int i = 0; i < 7; i++) run_single(vecs[i].idx, vecs[i].a, vecs[i].b, vecs[i].p);

    // All four contend right after reset: strict order 0..3.
    do_reset();
    @(posedge clk); #1;
    for (int i = 0; i < NREQ; i++) set_req(i, i + 1, 10);
    rsp_ready = '1;
    for (int k = 0; k < NREQ; k++) begin
      wait_grant("rr_grant", k);
      @(posedge clk); #1;
      req_valid[k] = 1'b0;
      wait_rsp("rr_rsp", k, 10 * (k + 1), lat);
      $display("rr req=%0d p=%0d", k, rsp_p);
    end

    // Response back-pressure; other rsp_ready bits must be ignored.
    @(posedge clk); #1;
    set_req(0, 9, 11);
    rsp_ready = 4'b1110;
    @(negedge clk);
    chk("stall_grant", req_ready, 1);
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    wait_rsp("stall_rsp", 0, 99, lat);
    @(posedge clk); #1;
    set_req(2, 3, 4);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("stall_valid", rsp_valid, 1);
      chk("stall_p", rsp_p, 99);
      chk("stall_ready", req_ready, 0);
      chk("stall_busy", busy, 1);
    end
    @(posedge clk); #1;
    rsp_ready = '1;
    @(negedge clk);
    @(negedge clk);
    chk("stall_next_grant", req_ready, 4);
    @(posedge clk); #1;
    req_valid[2] = 1'b0;
    wait_rsp("stall_rsp2", 2, 12, lat);
    $display("stall req0 p=99 held 5 cycles, then req2 p=%0d", rsp_p);

    // Two persistent requesters must alternate.
    do_reset();
    @(posedge clk); #1;
    set_req(0, 2, 3);
    set_req(2, 5, 7);
    rsp_ready = '1;
    for (int k = 0; k < 6; k++) begin
      wait_grant("alt_grant", (k % 2 == 0) ? 0 : 2);
      wait_rsp("alt_rsp", (k % 2 == 0) ? 0 : 2, (k % 2 == 0) ? 6 : 35, lat);
      $display("alt txn %0d req=%0d p=%0d", k, (k % 2 == 0) ? 0 : 2, rsp_p);
    end
    @(posedge clk); #1;
    req_valid = '0;

    // Reset pulse while the multiplier is settling.
    do_reset();
    @(posedge clk); #1;
    set_req(1, 7, 9);
    rsp_ready = '1;
    @(negedge clk);
    chk("abort_grant", req_ready, 2);
    @(posedge clk); #1;
    req_valid = '0;
    @(negedge clk);
    chk("abort_busy", busy, 1);
    chk("abort_mul_a", mul_a, 7);
    #1 rst = 1'b1;
    #1;
    chk("abort_busy0", busy, 0);
    chk("abort_rsp_valid", rsp_valid, 0);
    chk("abort_rsp_p", rsp_p, 0);
    chk("abort_mul_a0", mul_a, 0);
    chk("abort_mul_b0", mul_b, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    set_req(0, 4, 4);
    set_req(1, 6, 6);
    @(negedge clk);
    chk("abort_rsp_none", rsp_valid, 0);
    chk("abort_restart_grant", req_ready, 1);
    @(posedge clk); #1;
    req_valid = '0;
    wait_rsp("abort_rsp", 0, 16, lat);
    $display("abort then req0 p=%0d", rsp_p);

    // Randomized traffic against the round-robin reference model.
    do_reset();
    ptr = 0; mstate = 0; cnt = 0; eg = 0; ep = 0; jg = -1; ntx = 0;
    for (int i = 0; i < NREQ; i++) begin
      pend[i] = 0; opa[i] = 0; opb[i] = 0;
    end
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(posedge clk); #1;
      if (jg >= 0) begin
        pend[jg] = 0;
        req_valid[jg] = 1'b0;
        jg = -1;
      end
      for (int i = 0; i < NREQ; i++) begin
        if (pend[i] == 0 && $urandom_range(0, 3) == 0) begin
          pend[i] = 1;
          opa[i] = $urandom_range(0, 255);
          opb[i] = $urandom_range(0, 255);
          set_req(i, opa[i], opb[i]);
        end else if (pend[i] != 0 && $urandom_range(0, 31) == 0) begin
          pend[i] = 0;
          req_valid[i] = 1'b0;
        end
      end
      rsp_ready = 4'($urandom_range(0, 15));
      @(negedge clk);
      if (mstate == 0) begin
        g = -1;
        for (int k = 0; k < NREQ; k++) begin
          if (g < 0 && pend[(ptr + k) % NREQ] != 0) g = (ptr + k) % NREQ;
        end
        chk("rnd_grant", req_ready, (g >= 0) ? (32'd1 << g) : 0);
        chk("rnd_idle_busy", busy, 0);
        chk("rnd_idle_rsp", rsp_valid, 0);
        if (g >= 0) begin
          mstate = 1; cnt = 0; eg = g; ep = opa[g] * opb[g];
          ptr = (g + 1) % NREQ; jg = g;
        end
      end else begin
        cnt++;
        chk("rnd_busy_ready", req_ready, 0);
        chk("rnd_busy", busy, 1);
        if (cnt <= MUL_LAT) begin
          chk("rnd_early_rsp", rsp_valid, 0);
        end else begin
          chk("rnd_rsp_valid", rsp_valid, 32'd1 << eg);
          chk("rnd_rsp_p", rsp_p, ep);
          if (rsp_ready[eg]) begin
            mstate = 0;
            ntx++;
            $display("rnd txn %0d req=%0d p=%0d", ntx, eg, rsp_p);
          end
        end
        if (cnt > 200) begin
          n_cmp++;
          n_err++;
          $display("FAIL rnd_timeout: got no accept after %0d cycles expected accept", cnt);
          break;
        end
      end
    end
    gseq.delete();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
